// File: rtl/sd_sector_feeder.sv
// sd_sector_feeder: packs a valid/ready byte stream into 512-byte ping-pong sectors and
// drives one sd_write block write per full sector, auto-incrementing the sector address.
module sd_sector_feeder #(
    parameter logic [7:0]  PAD_BYTE     = 8'h00,
    parameter logic [31:0] DONE_TIMEOUT = 32'd4000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] base_sector,
    input  logic        base_load,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        StartWrite,
    output logic [31:0] writeSectorAddress,
    output logic [7:0]  inByte,
    input  logic        prepareNextByte,
    input  logic        writeBlockFinish,
    output logic [31:0] sectors_written,
    output logic        feeder_busy,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, LOAD, START, SEND, WAIT} state_t;
    state_t state, state_n;
    logic [7:0]  mem [0:1023];
    logic [7:0]  rd_data;
    logic [1:0]  full;
    logic        fill_bank, send_bank, padding, pnb_d;
    logic [8:0]  fill_ptr, rd_ptr;
    logic [31:0] next_sector, timer;
    logic        accept, wr_en, flush_go, advance, active, timeout, retire;

    assign in_ready = ~full[fill_bank] & ~padding;
    assign accept   = in_valid & in_ready;
    assign wr_en    = accept | padding;
    assign flush_go = flush & ~padding & (fill_ptr != 9'd0) & ~(accept & (fill_ptr == 9'h1ff));
    assign advance  = prepareNextByte & ~pnb_d;
    assign active   = (state == START) | (state == SEND) | (state == WAIT);
    assign timeout  = active & (timer >= DONE_TIMEOUT);
    assign retire   = (state == WAIT) & writeBlockFinish;

    // Byte 0 is read while still in IDLE so it is ready in LOAD.
    always_ff @(posedge clk) begin
        if (wr_en) mem[{fill_bank, fill_ptr}] <= padding ? PAD_BYTE : in_data;
        rd_data <= mem[{send_bank, (state == IDLE) ? 9'd0 : rd_ptr}];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full      <= 2'b00;
            fill_bank <= 1'b0;
            fill_ptr  <= 9'd0;
            padding   <= 1'b0;
        end else begin
            if (retire) full[send_bank] <= 1'b0;
            if (wr_en) fill_ptr <= fill_ptr + 9'd1;
            if (wr_en && fill_ptr == 9'h1ff) begin
                full[fill_bank] <= 1'b1;
                fill_bank       <= ~fill_bank;
                padding         <= 1'b0;
            end else if (flush_go) padding <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = full[send_bank] ? LOAD : IDLE;
            LOAD:    state_n = START;
            START:   state_n = timeout ? IDLE : advance ? SEND : START;
            SEND:    state_n = timeout ? IDLE : (advance && rd_ptr == 9'h1ff) ? WAIT : SEND;
            WAIT:    state_n = writeBlockFinish ? IDLE : timeout ? IDLE : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        StartWrite  = (state == START);
        feeder_busy = (|full) | (state != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pnb_d              <= 1'b0;
            timer              <= 32'd0;
            error              <= 1'b0;
            rd_ptr             <= 9'd0;
            send_bank          <= 1'b0;
            next_sector        <= 32'd0;
            writeSectorAddress <= 32'd0;
            inByte             <= 8'd0;
            sectors_written    <= 32'd0;
        end else begin
            pnb_d <= prepareNextByte;
            timer <= (state == LOAD) ? 32'd0 : active ? timer + 32'd1 : timer;
            if (timeout && !retire) error <= 1'b1;
            if (state == IDLE && full[send_bank]) begin
                rd_ptr             <= 9'd0;
                writeSectorAddress <= next_sector;
            end
            if (state == IDLE && base_load) next_sector <= base_sector;
            if ((state == START || state == SEND) && advance && rd_ptr != 9'h1ff) rd_ptr <= rd_ptr + 9'd1;
            if (state == LOAD || state == START || state == SEND) inByte <= rd_data;
            if (retire) begin
                send_bank       <= ~send_bank;
                next_sector     <= next_sector + 32'd1;
                sectors_written <= sectors_written + 32'd1;
            end
        end
    end
endmodule
